pipe_cla_adder: RTL and testbench
=================================

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4, minimum 8.
REQ-002 Parameter GROUP_W, default 4, lookahead group width; fixed at 4 in this revision.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operands and mode on the input port are valid.
REQ-006 in_ready  output  1  block accepts a transfer this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, used in add mode only.
REQ-010 sub  input  1  0 = A+B+cin, 1 = A-B.
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  WIDTH  result bits.
REQ-014 cout  output  1  carry out of the MSB; in subtract mode, 1 = no borrow.
REQ-015 ovf  output  1  signed overflow; present only with CLA_OVF_EN.

Function
REQ-016 Subtract SHALL be computed as A + ~B + 1, with cin ignored.
REQ-017 Stage 1 SHALL register the per-bit g=a&b', p=a^b' (b' = b or ~b) and the per-group G/P, together with the effective carry-in and a stage-1 valid flag.
REQ-018 Stage 2 SHALL compute group carries by two-level lookahead over the groups, with no ripple between groups, and register sum, cout and ovf.
REQ-019 Latency SHALL be exactly 2 clock edges from an accepted input to out_valid, absent stalls.
REQ-020 Throughput SHALL be one result per cycle while out_ready=1.
REQ-021 Transfers: input occurs on in_valid&in_ready; output occurs on out_valid&out_ready.
REQ-022 Stage 2 advances when !out_valid | out_ready; stage 1 advances when !s1_valid | (stage 2 advances).
REQ-023 in_ready SHALL equal the stage-1 advance condition, combinationally; no skid buffer is used.
REQ-024 While stalled, sum, cout, ovf and out_valid SHALL hold stable, and no accepted operand SHALL be lost or duplicated.
REQ-025 When input and output transfer in the same cycle with the pipeline full, both SHALL complete and occupancy SHALL remain 2.
REQ-026 out_valid SHALL never depend combinationally on in_valid.
REQ-027 Wrap-around: sum is mod 2^WIDTH and the carry appears only on cout.

Reset
REQ-028 Asserting rst at any time SHALL clear s1_valid and out_valid, and set sum=0, cout=0, ovf=0 asynchronously.
REQ-029 In-flight operations at reset SHALL be discarded and never emitted.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-031 With macro CLA_OVF_EN defined, port ovf SHALL exist and equal carry-into-MSB XOR carry-out-of-MSB, registered with sum.
REQ-032 Without CLA_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package cla_pkg SHALL hold the GROUP_W=4 constant, the mode encoding (MODE_ADD=0, MODE_SUB=1) and a WIDTH/GROUP_W group-count function.
REQ-034 Sub-module cla_group SHALL implement one 4-bit lookahead group: inputs g, p and c_in; outputs sum bits, group G and group P.
REQ-035 The top SHALL instantiate WIDTH/GROUP_W cla_group instances in a generate loop.
REQ-036 A WIDTH that is not a multiple of 4 SHALL cause an elaboration-time error.

Verification (WIDTH=16)
REQ-037 Add: a=0x00FF, b=0x0001, cin=0 -> 2 cycles later sum=0x0100, cout=0.
REQ-038 Wrap: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; with CLA_OVF_EN, ovf=0.
REQ-039 Sub and overflow: sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-040 Backpressure: stream 5 adds, hold out_ready=0 for 3 cycles -> in_ready falls after 2 accepts, results appear in order, none lost.
REQ-041 Reset mid-flight: rst during a cycle with 2 ops in flight -> out_valid=0 immediately, and neither op is ever emitted.
REQ-042 Random: 10k random a/b/cin/sub values with random out_ready, compared against a behavioural A±B model, zero mismatches.

Source files
------------

// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, mode encoding and helpers for the pipelined
// carry-lookahead adder (pipe_cla_adder, optional ovf port under CLA_OVF_EN).
package cla_pkg;

   localparam int GROUP_W = 4;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

   // Number of lookahead groups for a given operand width.
   function automatic int group_count(input int width);
      return width / GROUP_W;
   endfunction

   // Group generate/propagate of one 4-bit group, returned as {G, P}.
   function automatic logic [1:0] group_gp(input logic [GROUP_W-1:0] g,
                                           input logic [GROUP_W-1:0] p);
      logic grp_g;
      grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      return {grp_g, &p};
   endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: one 4-bit carry-lookahead group. Every internal carry is formed
// directly from g/p/c_in, so there is no ripple inside the group.
module cla_group
   import cla_pkg::*;
(
   input  logic [GROUP_W-1:0] g,
   input  logic [GROUP_W-1:0] p,
   input  logic               c_in,
   output logic [GROUP_W-1:0] sum,
   output logic               grp_g,
   output logic               grp_p
);

   logic [GROUP_W-1:0] c;

   // Bit carries of the group, each a flat sum of products.
   always_comb begin
      c[0] = c_in;
      c[1] = g[0] | (p[0] & c_in);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
   end

   assign sum            = p ^ c;
   assign {grp_g, grp_p} = group_gp(g, p);

endmodule

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: two-stage pipelined carry-lookahead adder/subtractor with
// valid/ready handshakes on both sides. Stage 1 registers bit and group g/p;
// stage 2 resolves group carries by lookahead and registers the result.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf.
module pipe_cla_adder #(
   parameter int WIDTH   = 16,
   parameter int GROUP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef CLA_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   import cla_pkg::*;

   localparam int NG = group_count(WIDTH);

   if ((WIDTH % GROUP_W) != 0 || WIDTH < 8 || GROUP_W != cla_pkg::GROUP_W) begin : g_bad_cfg
      $error("pipe_cla_adder: WIDTH must be a multiple of 4 and >= 8, GROUP_W must be 4");
   end

   mode_e            mode;
   logic [WIDTH-1:0] b_eff, g_in, p_in;
   logic [NG-1:0]    gg_in, gp_in;
   logic             c_eff;

   logic             s1_valid, s1_cin;
   logic [WIDTH-1:0] s1_g, s1_p;
   logic [NG-1:0]    s1_gg, s1_gp;

   logic             s1_adv, s2_adv;
   logic [NG:0]      grp_c;
   logic [WIDTH-1:0] sum_next;

   // Group G/P are already registered in stage 1; the copies the group
   // instances produce from the same g/p are not needed.
   logic [NG-1:0]    unused_gg, unused_gp;

   assign mode = mode_e'(sub);

   // Stage-1 operand conditioning: subtract is A + ~B + 1, cin ignored.
   always_comb begin
      // NOTE: every variable gets a value on every path before use; a path
      // that leaves one unassigned would infer a latch.
      b_eff = (mode == MODE_SUB) ? ~b : b;
      c_eff = (mode == MODE_SUB) ? 1'b1 : cin;
      g_in  = a & b_eff;
      p_in  = a ^ b_eff;
      gg_in = '0;
      gp_in = '0;
      for (int k = 0; k < NG; k++) begin
         {gg_in[k], gp_in[k]} = group_gp(g_in[k*GROUP_W +: GROUP_W], p_in[k*GROUP_W +: GROUP_W]);
      end
   end

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // Stage-1 register: captures g/p, group G/P and effective carry-in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_cin   <= 1'b0;
         s1_g     <= '0;
         s1_p     <= '0;
         s1_gg    <= '0;
         s1_gp    <= '0;
      end else if (s1_adv) begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_cin <= c_eff;
            s1_g   <= g_in;
            s1_p   <= p_in;
            s1_gg  <= gg_in;
            s1_gp  <= gp_in;
         end
      end
   end

   // Second-level lookahead: carry into group k is a flat OR of
   // G[j] & P[j+1..k-1] terms plus cin & P[0..k-1]; no group carry feeds another.
   always_comb begin
      logic acc, prod;
      acc      = 1'b0;
      prod     = 1'b1;
      grp_c    = '0;
      grp_c[0] = s1_cin;
      for (int k = 1; k <= NG; k++) begin
         acc  = 1'b0;
         prod = 1'b1;
         for (int j = k - 1; j >= 0; j--) begin
            acc  = acc | (s1_gg[j] & prod);
            prod = prod & s1_gp[j];
         end
         grp_c[k] = acc | (s1_cin & prod);
      end
   end

   for (genvar k = 0; k < NG; k++) begin : g_grp
      cla_group u_grp (
         .g     (s1_g[k*GROUP_W +: GROUP_W]),
         .p     (s1_p[k*GROUP_W +: GROUP_W]),
         .c_in  (grp_c[k]),
         .sum   (sum_next[k*GROUP_W +: GROUP_W]),
         .grp_g (unused_gg[k]),
         .grp_p (unused_gp[k])
      );
   end

   // Stage-2 register: result held stable while downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
`ifdef CLA_OVF_EN
         ovf       <= 1'b0;
`endif
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            sum  <= sum_next;
            cout <= grp_c[NG];
`ifdef CLA_OVF_EN
            // Carry into the MSB is recovered as sum[MSB] ^ p[MSB].
            ovf  <= sum_next[WIDTH-1] ^ s1_p[WIDTH-1] ^ grp_c[NG];
`endif
         end
      end
   end

endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb_pipe_cla_adder: self-checking bench for pipe_cla_adder (WIDTH=16).
// Directed vectors, backpressure, mid-flight reset and a randomized run,
// all scored against an arithmetic A+B+cin / A-B reference model.
// Build with CLA_OVF_EN defined to also score the ovf port.
module tb_pipe_cla_adder;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready;
   logic [W-1:0] a, b;
   logic         cin, sub;
   logic         out_valid, out_ready;
   logic [W-1:0] sum;
   logic         cout;
`ifdef CLA_OVF_EN
   logic         ovf;
`endif

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   exp_t         q[$];
   int           n_vec = 0;
   int           n_err = 0;
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_sum  = '0;
   logic         prev_cout = 1'b0;

   pipe_cla_adder #(.WIDTH(W), .GROUP_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
`ifdef CLA_OVF_EN
      .ovf       (ovf),
`endif
      .cout      (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c, input logic s);
      exp_t         r;
      logic [W:0]   full;
      int           sx, sy, sr;
      sx = $signed(x);
      sy = $signed(y);
      if (s) begin
         r.sum  = x - y;
         r.cout = (x >= y);
         sr     = sx - sy;
      end else begin
         full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
         r.sum  = full[W-1:0];
         r.cout = full[W];
         sr     = sx + sy + int'(c);
      end
      r.ovf = (sr > (2**(W-1)) - 1) || (sr < -(2**(W-1)));
      return r;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom());
      endcase
   endfunction

   // One cycle: drive at negedge, then score handshakes that the next posedge commits.
   task automatic step(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic ts, input logic tr, output logic acc);
      exp_t e;
      @(negedge clk);
      in_valid  = v;
      a         = ta;
      b         = tb_;
      cin       = tc;
      sub       = ts;
      out_ready = tr;
      #1;
      if (prev_stall) begin
         check("hold_valid", out_valid, 1);
         check("hold_sum", sum, prev_sum);
         check("hold_cout", cout, prev_cout);
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_cout  = cout;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            check("spurious_out", out_valid, 0);
         end else begin
            e = q.pop_front();
            check("sum", sum, e.sum);
            check("cout", cout, e.cout);
`ifdef CLA_OVF_EN
            check("ovf", ovf, e.ovf);
`endif
         end
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(ta, tb_, tc, ts));
   endtask

   task automatic drain();
      logic acc;
      for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) begin
         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      end
      check("drain_empty", q.size(), 0);
   endtask

   task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
      logic acc;
      step(1'b1, ta, tb_, tc, ts, 1'b1, acc);
      check("dir_accept", acc, 1);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      check("dir_lat1_valid", out_valid, 0);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      check("dir_lat2_valid", out_valid, 1);
      check("dir_sum", sum, es);
      check("dir_cout", cout, ec);
`ifdef CLA_OVF_EN
      check("dir_ovf", ovf, eo);
`endif
   endtask

   initial begin
      logic acc;
      int   n_acc;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;

      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("in_ready_after_rst", in_ready, 1);

      // Directed: plain add, wrap-around, subtract with signed overflow.
      run_one(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_one(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      drain();

      // Backpressure: five adds, out_ready low for the first three cycles.
      n_acc = 0;
      for (int cyc = 0; cyc < 40 && n_acc < 5; cyc++) begin
         step(1'b1, 16'h1000 + W'(n_acc), W'(n_acc * 3), n_acc[0], 1'b0, cyc >= 3, acc);
         if (cyc == 2) begin
            check("bp_in_ready_low", in_ready, 0);
            check("bp_accepts", n_acc, 2);
         end
         if (acc) n_acc++;
      end
      check("bp_all_accepted", n_acc, 5);
      drain();

      // Reset with two operations in flight.
      step(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 16'h4321, 16'h0101, 1'b1, 1'b0, 1'b0, acc);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_sum", sum, 0);
      check("midrst_cout", cout, 0);
      q.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_in_ready", in_ready, 1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
         check("midrst_no_emit", out_valid, 0);
      end

      // Randomized traffic with random downstream stalls.
      for (int i = 0; i < 10000; i++) begin
         step($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, acc);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

endmodule
